// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU sequencing/sharing controller.
//   WORD_SIZE - default operand/result width
//   OP_*      - 5-bit opcodes; any other value passes operand A through
//   state_e   - controller states
package alu_pkg;

  localparam int unsigned WORD_SIZE = 32;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_DIV = 5'd2;
  localparam logic [4:0] OP_AND = 5'd3;
  localparam logic [4:0] OP_OR  = 5'd4;
  localparam logic [4:0] OP_XOR = 5'd5;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DIV,
    RESP
  } state_e;

endpackage

// File: rtl/alu_divider.sv
// alu_divider: restoring unsigned divider, one quotient bit per cycle.
//   i_clk, i_reset   - clock, synchronous active-high reset
//   i_start          - load i_a / i_b; the first iteration runs on this edge
//   i_a, i_b         - dividend, divisor (sampled only with i_start)
//   o_busy           - iterations outstanding
//   o_done           - 1-cycle pulse, WordSize cycles after i_start
//   o_quotient       - quotient, valid while o_done is high
// A zero divisor always subtracts successfully, so the quotient is all ones.
module alu_divider
  import alu_pkg::*;
#(
  parameter int unsigned WordSize = WORD_SIZE
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [WordSize-1:0] i_a,
  input  logic [WordSize-1:0] i_b,
  output logic                o_busy,
  output logic                o_done,
  output logic [WordSize-1:0] o_quotient
);

  localparam int unsigned CntW = $clog2(WordSize + 1);

  logic [WordSize-1:0] r_rem, r_quo, r_div;
  logic [CntW-1:0]     r_cnt;
  logic                r_busy, r_done;

  logic [WordSize-1:0] w_rem_in, w_quo_in, w_div_in, w_rem_nx, w_quo_nx;
  logic [WordSize:0]   w_shift, w_diff;

  // One restoring step; on start it operates on the fresh operands so the
  // whole divide fits in WordSize edges.
  always_comb begin
    w_rem_in = i_start ? '0 : r_rem;
    w_quo_in = i_start ? i_a : r_quo;
    w_div_in = i_start ? i_b : r_div;
    w_shift  = {w_rem_in, w_quo_in[WordSize-1]};
    w_diff   = w_shift - {1'b0, w_div_in};
    if (w_shift >= {1'b0, w_div_in}) begin
      w_rem_nx = w_diff[WordSize-1:0];
      w_quo_nx = {w_quo_in[WordSize-2:0], 1'b1};
    end else begin
      w_rem_nx = w_shift[WordSize-1:0];
      w_quo_nx = {w_quo_in[WordSize-2:0], 1'b0};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_rem  <= w_rem_nx;
        r_quo  <= w_quo_nx;
        r_div  <= i_b;
        r_cnt  <= CntW'(1);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_rem <= w_rem_nx;
        r_quo <= w_quo_nx;
        r_cnt <= r_cnt + CntW'(1);
        if (r_cnt == CntW'(WordSize - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_quotient = r_quo;

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of the integer ALU between two requesters.
//   i_clk, i_reset                 - clock, synchronous active-high reset
//   i_reqN_valid / o_reqN_ready    - request handshake, N = 0, 1
//   i_reqN_a, i_reqN_b, i_reqN_sel - operands and opcode
//   o_resp_valid / i_resp_ready    - response handshake
//   o_resp_result, o_resp_carry    - registered result, carry/borrow
//   o_resp_id                      - requester that issued the op
// Single-cycle ops run on latched operands in EXEC; DIV runs in alu_divider.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WordSize = WORD_SIZE
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_req0_valid,
  output logic                o_req0_ready,
  input  logic [WordSize-1:0] i_req0_a,
  input  logic [WordSize-1:0] i_req0_b,
  input  logic [4:0]          i_req0_sel,
  input  logic                i_req1_valid,
  output logic                o_req1_ready,
  input  logic [WordSize-1:0] i_req1_a,
  input  logic [WordSize-1:0] i_req1_b,
  input  logic [4:0]          i_req1_sel,
  output logic                o_resp_valid,
  input  logic                i_resp_ready,
  output logic [WordSize-1:0] o_resp_result,
  output logic                o_resp_carry,
  output logic                o_resp_id
);

  state_e              r_state, w_state_nx;
  logic                r_ptr;
  logic [WordSize-1:0] r_a, r_b;
  logic [4:0]          r_sel;
  logic                r_id;
  logic [WordSize-1:0] r_result;
  logic                r_carry, r_resp_id;

  logic                w_win, w_accept;
  logic [WordSize-1:0] w_a, w_b;
  logic [4:0]          w_sel;
  logic [WordSize:0]   w_sum;
  logic [WordSize-1:0] w_alu_res;
  logic                w_alu_carry;
  logic                w_div_start, w_div_busy, w_div_done;
  logic [WordSize-1:0] w_quot;

  // Grant: pointer breaks ties, a lone valid requester always wins.
  always_comb begin
    w_win        = (i_req0_valid && i_req1_valid) ? r_ptr : i_req1_valid;
    o_req0_ready = (r_state == IDLE) && !i_reset && !w_div_busy && i_req0_valid && !w_win;
    o_req1_ready = (r_state == IDLE) && !i_reset && !w_div_busy && i_req1_valid && w_win;
    w_accept     = o_req0_ready || o_req1_ready;
    w_a          = w_win ? i_req1_a : i_req0_a;
    w_b          = w_win ? i_req1_b : i_req0_b;
    w_sel        = w_win ? i_req1_sel : i_req0_sel;
    w_div_start  = w_accept && (w_sel == OP_DIV);
  end

  always_comb begin
    w_sum       = {1'b0, r_a} + {1'b0, r_b};
    w_alu_res   = r_a;
    w_alu_carry = 1'b0;
    case (r_sel)
      OP_ADD: begin
        w_alu_res   = w_sum[WordSize-1:0];
        w_alu_carry = w_sum[WordSize];
      end
      OP_SUB: begin
        w_alu_res   = r_a - r_b;
        w_alu_carry = (r_a < r_b);
      end
      OP_AND:  w_alu_res = r_a & r_b;
      OP_OR:   w_alu_res = r_a | r_b;
      OP_XOR:  w_alu_res = r_a ^ r_b;
      default: w_alu_res = r_a;
    endcase
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nx = (w_sel == OP_DIV) ? DIV : EXEC;
      EXEC:    w_state_nx = RESP;
      DIV:     if (w_div_done) w_state_nx = RESP;
      RESP:    if (i_resp_ready) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_ptr     <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_sel     <= '0;
      r_id      <= 1'b0;
      r_result  <= '0;
      r_carry   <= 1'b0;
      r_resp_id <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (w_accept) begin
        r_a   <= w_a;
        r_b   <= w_b;
        r_sel <= w_sel;
        r_id  <= w_win;
        r_ptr <= ~w_win;
      end
      if (r_state == EXEC) begin
        r_result  <= w_alu_res;
        r_carry   <= w_alu_carry;
        r_resp_id <= r_id;
      end else if (r_state == DIV && w_div_done) begin
        r_result  <= w_quot;
        r_carry   <= 1'b0;
        r_resp_id <= r_id;
      end
    end
  end

  assign o_resp_valid  = (r_state == RESP);
  assign o_resp_result = r_result;
  assign o_resp_carry  = r_carry;
  assign o_resp_id     = r_resp_id;

  alu_divider #(
    .WordSize(WordSize)
  ) u_divider (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_start   (w_div_start),
    .i_a       (w_a),
    .i_b       (w_b),
    .o_busy    (w_div_busy),
    .o_done    (w_div_done),
    .o_quotient(w_quot)
  );

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [4:0]  req0_sel, req1_sel;
  logic        resp_valid, resp_ready, resp_carry, resp_id;
  logic [31:0] resp_result;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_req0_valid (req0_valid),
    .o_req0_ready (req0_ready),
    .i_req0_a     (req0_a),
    .i_req0_b     (req0_b),
    .i_req0_sel   (req0_sel),
    .i_req1_valid (req1_valid),
    .o_req1_ready (req1_ready),
    .i_req1_a     (req1_a),
    .i_req1_b     (req1_b),
    .i_req1_sel   (req1_sel),
    .o_resp_valid (resp_valid),
    .i_resp_ready (resp_ready),
    .o_resp_result(resp_result),
    .o_resp_carry (resp_carry),
    .o_resp_id    (resp_id)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: one transaction in flight, response due lat cycles after accept.
  bit          m_ptr, m_busy;
  int          m_age, m_lat;
  logic [31:0] m_res;
  logic        m_carry;
  bit          m_id;
  int          cyc, acc_cyc, resp_lat;
  bit          seen_valid, acc0, acc1;
  int          n_resp;
  bit          grants[$];
  logic [32:0] resps[$];   // {id, result}
  logic [31:0] last_res;
  logic        last_carry, last_id;

  function automatic logic [32:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic [4:0] sel);
    logic [32:0] r;
    longint unsigned s;
    case (sel)
      5'd0: begin
        s = longint'(a) + longint'(b);
        r = {(s > 64'hFFFF_FFFF), a + b};
      end
      5'd1: r = {(a < b), a - b};
      5'd2: r = (b == 0) ? {1'b0, 32'hFFFF_FFFF} : {1'b0, a / b};
      5'd3: r = {1'b0, a & b};
      5'd4: r = {1'b0, a | b};
      5'd5: r = {1'b0, a ^ b};
      default: r = {1'b0, a};
    endcase
    return r;
  endfunction

  // Called at a negedge with inputs set; checks this cycle, advances the model
  // across the next posedge, returns at the following negedge.
  task automatic step();
    bit e0, e1, win1, exp_rv;
    logic [32:0] r;
    #1;
    exp_rv = m_busy && (m_age >= m_lat);
    win1   = (req0_valid && req1_valid) ? m_ptr : req1_valid;
    e0     = !m_busy && !reset && req0_valid && !win1;
    e1     = !m_busy && !reset && req1_valid && win1;
    check_eq("req0_ready", req0_ready, e0);
    check_eq("req1_ready", req1_ready, e1);
    check_eq("resp_valid", resp_valid, exp_rv);
    if (exp_rv) begin
      check_eq("resp_result", resp_result, m_res);
      check_eq("resp_carry", resp_carry, m_carry);
      check_eq("resp_id", resp_id, m_id);
    end
    if (resp_valid && !seen_valid) begin
      resp_lat   = cyc - acc_cyc;
      seen_valid = 1;
    end
    if (exp_rv && resp_ready) begin
      last_res   = resp_result;
      last_carry = resp_carry;
      last_id    = resp_id;
      resps.push_back({resp_id, resp_result});
      n_resp++;
    end
    if (reset) begin
      m_ptr  = 0;
      m_busy = 0;
    end else if (e0 || e1) begin
      r = win1 ? ref_op(req1_a, req1_b, req1_sel) : ref_op(req0_a, req0_b, req0_sel);
      m_carry    = r[32];
      m_res      = r[31:0];
      m_lat      = ((win1 ? req1_sel : req0_sel) == 5'd2) ? 33 : 2;
      m_id       = win1;
      m_busy     = 1;
      m_age      = 1;
      m_ptr      = !win1;
      acc_cyc    = cyc;
      seen_valid = 0;
      grants.push_back(win1);
    end else if (m_busy) begin
      if (exp_rv && resp_ready) m_busy = 0;
      else m_age++;
    end
    acc0 = e0;
    acc1 = e1;
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_op(input bit id, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sel);
    int k;
    int n0;
    req0_valid = 0;
    req1_valid = 0;
    if (id) begin
      req1_valid = 1; req1_a = a; req1_b = b; req1_sel = sel;
    end else begin
      req0_valid = 1; req0_a = a; req0_b = b; req0_sel = sel;
    end
    resp_ready = 1;
    acc0 = 0;
    acc1 = 0;
    k = 0;
    while (!(id ? acc1 : acc0) && k < 50) begin step(); k++; end
    check_eq("op_accept", k < 50, 1);
    req0_valid = 0;
    req1_valid = 0;
    n0 = n_resp;
    k = 0;
    while (n_resp == n0 && k < 100) begin step(); k++; end
    check_eq("op_response", k < 100, 1);
  endtask

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(3))
      0: return 32'($urandom_range(1));
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(15));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [4:0] rnd_sel();
    if ($urandom_range(3) == 0) return 5'($urandom);
    return 5'($urandom_range(5));
  endfunction

  initial begin
    int k;
    reset = 1; resp_ready = 0;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_sel = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_sel = 0;
    m_ptr = 0; m_busy = 0; m_age = 0; m_lat = 2; cyc = 0; n_resp = 0;
    @(negedge clk);
    check_eq("rst_result", resp_result, 0);
    check_eq("rst_carry", resp_carry, 0);
    check_eq("rst_id", resp_id, 0);
    req0_valid = 1;
    step();                       // reset still high: no ready despite valid
    reset = 0;
    req0_valid = 0;
    step();

    run_op(0, 32'hFFFF_FFFF, 32'd1, 5'd0);
    check_eq("add_result", last_res, 0);
    check_eq("add_carry", last_carry, 1);
    check_eq("add_id", last_id, 0);
    check_eq("add_latency", resp_lat, 2);

    run_op(0, 32'd3, 32'd5, 5'd1);
    check_eq("sub_result", last_res, 32'hFFFF_FFFE);
    check_eq("sub_borrow", last_carry, 1);

    run_op(1, 32'h1234, 32'h99, 5'd7);
    check_eq("pass_result", last_res, 32'h1234);
    check_eq("pass_carry", last_carry, 0);

    // Contention: both held valid, pointer is 0 after the req1 grant above.
    grants.delete();
    resps.delete();
    req0_valid = 1; req0_a = 1;   req0_b = 1;   req0_sel = 5'd0;
    req1_valid = 1; req1_a = 'hF; req1_b = 'h3; req1_sel = 5'd5;
    resp_ready = 1;
    for (int i = 0; i < 13; i++) step();
    req0_valid = 0; req1_valid = 0;
    for (int i = 0; i < 4; i++) step();
    check_eq("cont_grants", grants.size() >= 4, 1);
    check_eq("cont_resps", resps.size() >= 4, 1);
    if (grants.size() >= 4 && resps.size() >= 4) begin
      check_eq("cont_grant0", grants[0], 0);
      check_eq("cont_grant1", grants[1], 1);
      check_eq("cont_grant2", grants[2], 0);
      check_eq("cont_grant3", grants[3], 1);
      check_eq("cont_resp0", resps[0], {1'b0, 32'd2});
      check_eq("cont_resp1", resps[1], {1'b1, 32'hC});
      check_eq("cont_resp2", resps[2], {1'b0, 32'd2});
      check_eq("cont_resp3", resps[3], {1'b1, 32'hC});
    end

    run_op(1, 32'd100, 32'd7, 5'd2);
    check_eq("div_result", last_res, 32'd14);
    check_eq("div_id", last_id, 1);
    check_eq("div_latency", resp_lat, 33);
    run_op(0, 32'd5, 32'd0, 5'd2);
    check_eq("div0_result", last_res, 32'hFFFF_FFFF);
    check_eq("div0_carry", last_carry, 0);
    check_eq("div0_latency", resp_lat, 33);

    // Backpressure: response held 5 cycles, waiting req1 never readied.
    req0_valid = 1; req0_a = 10; req0_b = 20; req0_sel = 5'd0;
    resp_ready = 0;
    acc0 = 0;
    k = 0;
    while (!acc0 && k < 20) begin step(); k++; end
    req0_valid = 0;
    req1_valid = 1; req1_a = 7; req1_b = 7; req1_sel = 5'd3;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("bp_valid", resp_valid, 1);
      check_eq("bp_result", resp_result, 32'd30);
      check_eq("bp_ready1", req1_ready, 0);
    end
    req1_valid = 0;
    resp_ready = 1;
    step();
    step();

    // Reset during DIV: pointer is 1 after the req0 grant, reset must clear it.
    req0_valid = 1; req0_a = 1000; req0_b = 3; req0_sel = 5'd2;
    acc0 = 0;
    k = 0;
    while (!acc0 && k < 20) begin step(); k++; end
    req0_valid = 0;
    for (int i = 0; i < 9; i++) step();
    k = n_resp;
    reset = 1;
    step();
    reset = 0;
    check_eq("rst_div_valid", resp_valid, 0);
    for (int i = 0; i < 40; i++) step();
    check_eq("rst_div_noresp", n_resp, k);
    grants.delete();
    req0_valid = 1; req0_a = 2; req0_b = 2; req0_sel = 5'd0;
    req1_valid = 1; req1_a = 3; req1_b = 3; req1_sel = 5'd0;
    step();
    check_eq("rst_ptr_grant", (grants.size() == 1) ? grants[0] : 1'b1, 0);
    req0_valid = 0; req1_valid = 0;
    for (int i = 0; i < 4; i++) step();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      if (acc0 || !req0_valid || $urandom_range(7) == 0) begin
        req0_valid = 1'($urandom_range(1));
        req0_a = rnd_word(); req0_b = rnd_word(); req0_sel = rnd_sel();
      end
      if (acc1 || !req1_valid || $urandom_range(7) == 0) begin
        req1_valid = 1'($urandom_range(1));
        req1_a = rnd_word(); req1_b = rnd_word(); req1_sel = rnd_sel();
      end
      resp_ready = ($urandom_range(3) != 0);
      reset = ($urandom_range(299) == 0);
      step();
    end
    reset = 0;
    req0_valid = 0;
    req1_valid = 0;
    resp_ready = 1;
    for (int i = 0; i < 40; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
